// File: rtl/ahb_uart0_if.sv
// AHB-Lite data-port bundle between the CPU initiator and the uart0 responder.
interface ahb_uart0_if;
  logic        HSELx;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;

  modport master (output HSELx, HADDR, HWRITE, HSIZE, HTRANS, HWDATA,
                  input  HRDATA, HREADY, HRESP);
  modport slave  (input  HSELx, HADDR, HWRITE, HSIZE, HTRANS, HWDATA,
                  output HRDATA, HREADY, HRESP);
endinterface

// File: rtl/ahb_uart0.sv
// uart0 AHB-Lite responder: zero-wait register file, TX FIFO into an 8N1 serializer, 8N1 deserializer.
// Optional UART0_IRQ_EN adds the IE register at 0x10 and the irq_uart output.
//
// state    | meaning
// TX_IDLE  | line high, waiting for a FIFO entry
// TX_START | driving start bit (0)
// TX_DATA  | driving 8 data bits, LSB first
// TX_STOP  | driving stop bit (1); chains straight into TX_START if FIFO has data
// RX_IDLE  | waiting for synchronized falling edge
// RX_START | counting to mid start bit; high there means false start
// RX_DATA  | sampling 8 data bits
// RX_STOP  | sampling stop bit, then deliver or flag
module ahb_uart0 #(
  parameter int unsigned TX_DEPTH    = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic       clk,
  input  logic       rst,
  ahb_uart0_if.slave bus,
  output logic       uart_tx,
  input  logic       uart_rx
`ifdef UART0_IRQ_EN
  ,
  output logic       irq_uart
`endif
);
  localparam int unsigned AW = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic        dp_valid, dp_write, err_c2;
  logic [9:0]  dp_addr;
  logic        addr_ok, dp_bad, wr_en, rd_en, w1c, rd_rx;
  logic [15:0] div;
  logic        tx_ovf, rx_ovr, frame_err, rx_valid;
  logic [7:0]  rx_byte;

  always_comb begin
    addr_ok = (dp_addr < 10'd4);
`ifdef UART0_IRQ_EN
    if (dp_addr == 10'd4) addr_ok = 1'b1;
`endif
  end

  assign dp_bad     = dp_valid && !addr_ok;
  assign wr_en      = dp_valid && addr_ok && dp_write;
  assign rd_en      = dp_valid && addr_ok && !dp_write;
  assign w1c        = wr_en && (dp_addr == 10'd2);
  assign rd_rx      = rd_en && (dp_addr == 10'd1);
  assign bus.HREADY = !dp_bad;
  assign bus.HRESP  = (dp_bad || err_c2) ? 2'b01 : 2'b00;

  // A bad offset holds one stall cycle; any address phase offered then is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      err_c2   <= 1'b0;
    end else begin
      err_c2 <= dp_bad;
      if (dp_bad) begin
        dp_valid <= 1'b0;
      end else begin
        dp_valid <= bus.HSELx && bus.HTRANS[1];
        dp_addr  <= bus.HADDR[11:2];
        dp_write <= bus.HWRITE;
      end
    end
  end

  logic [7:0]  mem [TX_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        tx_full, tx_empty, push, pop;

  assign tx_empty = (wptr == rptr);
  assign tx_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push     = wr_en && (dp_addr == 10'd0);

  always_ff @(posedge clk) begin
    if (push && !tx_full) mem[wptr[AW-1:0]] <= bus.HWDATA[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !tx_full) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (pop)              rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  tx_state_t   tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_sh;
  logic        tx_busy;

  assign tx_busy = (tx_state != TX_IDLE);
  assign pop     = !tx_empty && ((tx_state == TX_IDLE) ||
                                 (tx_state == TX_STOP && tx_cnt == 16'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: if (pop) begin
          tx_sh    <= mem[rptr[AW-1:0]];
          tx_cnt   <= div;
          uart_tx  <= 1'b0;
          tx_state <= TX_START;
        end
        TX_START: if (tx_cnt == 16'd0) begin
          tx_cnt   <= div;
          tx_idx   <= '0;
          uart_tx  <= tx_sh[0];
          tx_state <= TX_DATA;
        end else tx_cnt <= tx_cnt - 16'd1;
        TX_DATA: if (tx_cnt == 16'd0) begin
          tx_cnt <= div;
          if (tx_idx == 3'd7) begin
            uart_tx  <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            tx_sh   <= tx_sh >> 1;
            uart_tx <= tx_sh[1];
            tx_idx  <= tx_idx + 3'd1;
          end
        end else tx_cnt <= tx_cnt - 16'd1;
        TX_STOP: if (tx_cnt == 16'd0) begin
          if (pop) begin
            tx_sh    <= mem[rptr[AW-1:0]];
            tx_cnt   <= div;
            uart_tx  <= 1'b0;
            tx_state <= TX_START;
          end else tx_state <= TX_IDLE;
        end else tx_cnt <= tx_cnt - 16'd1;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  rx_state_t   rx_state;
  logic        rx_s1, rx_s2, rx_prev;
  logic [15:0] rx_cnt, half;
  logic [16:0] half_full;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_sh;
  logic        rx_sample, rx_good, rx_bad_stop, rx_load, rx_drop;

  assign half_full   = ({1'b0, div} + 17'd1) >> 1;
  assign half        = half_full[15:0];
  assign rx_sample   = (rx_state != RX_IDLE) && (rx_cnt == 16'd0);
  assign rx_good     = (rx_state == RX_STOP) && rx_sample && rx_s2;
  assign rx_bad_stop = (rx_state == RX_STOP) && rx_sample && !rx_s2;
  // A same-cycle RXDATA read frees the holding register for the incoming byte.
  assign rx_load     = rx_good && (!rx_valid || rd_rx);
  assign rx_drop     = rx_good && rx_valid && !rd_rx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_s2) begin
          rx_cnt   <= (half == 16'd0) ? 16'd0 : half - 16'd1;
          rx_state <= RX_START;
        end
        RX_START: if (rx_sample) begin
          rx_cnt   <= div;
          rx_idx   <= '0;
          rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt - 16'd1;
        RX_DATA: if (rx_sample) begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_cnt <= div;
          if (rx_idx == 3'd7) rx_state <= RX_STOP;
          else                rx_idx   <= rx_idx + 3'd1;
        end else rx_cnt <= rx_cnt - 16'd1;
        RX_STOP: if (rx_sample) rx_state <= RX_IDLE;
                 else           rx_cnt   <= rx_cnt - 16'd1;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Flag-set events win over a same-cycle W1C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div       <= DEFAULT_DIV;
      tx_ovf    <= 1'b0;
      rx_ovr    <= 1'b0;
      frame_err <= 1'b0;
      rx_valid  <= 1'b0;
      rx_byte   <= '0;
    end else begin
      if (wr_en && dp_addr == 10'd3) div <= bus.HWDATA[15:0];
      if (push && tx_full)                tx_ovf <= 1'b1;
      else if (w1c && bus.HWDATA[4])      tx_ovf <= 1'b0;
      if (rx_drop)                        rx_ovr <= 1'b1;
      else if (w1c && bus.HWDATA[5])      rx_ovr <= 1'b0;
      if (rx_bad_stop)                    frame_err <= 1'b1;
      else if (w1c && bus.HWDATA[6])      frame_err <= 1'b0;
      if (rx_load) begin
        rx_valid <= 1'b1;
        rx_byte  <= rx_sh;
      end else if (rd_rx) rx_valid <= 1'b0;
    end
  end

`ifdef UART0_IRQ_EN
  logic [1:0] ie;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie       <= '0;
      irq_uart <= 1'b0;
    end else begin
      if (wr_en && dp_addr == 10'd4) ie <= bus.HWDATA[1:0];
      irq_uart <= (ie[0] & tx_empty) | (ie[1] & rx_valid);
    end
  end
`endif

  always_comb begin
    bus.HRDATA = '0;
    if (rd_en) begin
      case (dp_addr)
        10'd1:   bus.HRDATA = {rx_valid, 23'b0, rx_byte};
        10'd2:   bus.HRDATA = {25'b0, frame_err, rx_ovr, tx_ovf, rx_valid,
                               tx_busy, tx_empty, tx_full};
        10'd3:   bus.HRDATA = {16'b0, div};
`ifdef UART0_IRQ_EN
        10'd4:   bus.HRDATA = {30'b0, ie};
`endif
        default: bus.HRDATA = '0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.HSIZE, bus.HADDR[31:12], bus.HADDR[1:0],
                         bus.HWDATA[31:16], half_full[16]};
endmodule

// File: tb/tb_ahb_uart0.sv
// Self-checking bench for ahb_uart0: register vector table, serial waveform checks, randomized RX/TX against a byte-level model.
module tb_ahb_uart0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_tx;
  logic uart_rx = 1'b1;
`ifdef UART0_IRQ_EN
  logic irq_uart;
`endif

  ahb_uart0_if bus();

  ahb_uart0 dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .uart_tx (uart_tx),
    .uart_rx (uart_rx)
`ifdef UART0_IRQ_EN
    ,
    .irq_uart(irq_uart)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cur_bits = 434;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ahb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic rdy1, output logic [1:0] resp1,
                          output logic rdy2, output logic [1:0] resp2);
    bus.HSELx = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = addr; bus.HWRITE = wr;
    @(posedge clk); #1;
    bus.HSELx = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = wdata;
    @(negedge clk);
    rdata = bus.HRDATA; rdy1 = bus.HREADY; resp1 = bus.HRESP;
    rdy2 = rdy1; resp2 = resp1;
    @(posedge clk); #1;
    if (!rdy1) begin
      @(negedge clk);
      rdy2 = bus.HREADY; resp2 = bus.HRESP;
      @(posedge clk); #1;
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    logic r1, r2;
    logic [1:0] p1, p2;
    ahb_xfer(a, 1'b0, 32'h0, d, r1, p1, r2, p2);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] x;
    logic r1, r2;
    logic [1:0] p1, p2;
    ahb_xfer(a, 1'b1, d, x, r1, p1, r2, p2);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int bits);
    uart_rx = 1'b0; cyc(bits);
    for (int k = 0; k < 8; k++) begin
      uart_rx = b[k]; cyc(bits);
    end
    uart_rx = stop; cyc(bits);
    uart_rx = 1'b1; cyc(3 * bits);
  endtask

  // Behavioural line receiver: decodes uart_tx frames into a byte queue.
  logic [7:0] mon_q[$];
  logic [7:0] mon_b;
  logic       mon_prev = 1'b1;
  always begin
    @(negedge clk);
    if (!uart_tx && mon_prev) begin
      repeat (cur_bits / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (cur_bits) @(negedge clk);
        mon_b[k] = uart_tx;
      end
      repeat (cur_bits) @(negedge clk);
      mon_q.push_back(mon_b);
    end
    mon_prev = uart_tx;
  end

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        err;
    string       name;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [31:0] wd,
                              input logic [31:0] e, input logic er, input string n);
    mk.addr = a; mk.wr = w; mk.wdata = wd; mk.exp = e; mk.err = er; mk.name = n;
  endfunction

  localparam int NV = 14;
  vec_t vecs[NV];

  initial begin
    logic [31:0] d;
    logic r1, r2;
    logic [1:0] p1, p2;
    logic ok;
    logic [39:0] sv;
    logic [9:0] fr;
    logic [7:0] b;
    logic stop;
    int bits, lows;
    logic m_valid, m_ovr, m_ferr;
    logic [7:0] m_byte;

    vecs[0]  = mk(32'h08,  1'b0, 32'h0,        32'h2,     1'b0, "status_rst");
    vecs[1]  = mk(32'h0C,  1'b0, 32'h0,        32'h1B1,   1'b0, "div_rst");
    vecs[2]  = mk(32'h04,  1'b0, 32'h0,        32'h0,     1'b0, "rxdata_rst");
    vecs[3]  = mk(32'h00,  1'b0, 32'h0,        32'h0,     1'b0, "txdata_rd");
    vecs[4]  = mk(32'h0C,  1'b1, 32'hABCD1234, 32'h0,     1'b0, "div_wr");
    vecs[5]  = mk(32'h0F,  1'b0, 32'h0,        32'h1234,  1'b0, "div_rd_lowbits");
    vecs[6]  = mk(32'h08,  1'b1, 32'h7F,       32'h0,     1'b0, "w1c_idle");
    vecs[7]  = mk(32'h08,  1'b0, 32'h0,        32'h2,     1'b0, "status_after_w1c");
    vecs[8]  = mk(32'h20,  1'b0, 32'h0,        32'h0,     1'b1, "err_0x20");
`ifdef UART0_IRQ_EN
    vecs[9]  = mk(32'h10,  1'b0, 32'h0,        32'h0,     1'b0, "ie_rd");
`else
    vecs[9]  = mk(32'h10,  1'b0, 32'h0,        32'h0,     1'b1, "err_0x10");
`endif
    vecs[10] = mk(32'h0C,  1'b1, 32'h3,        32'h0,     1'b0, "div_wr3");
    vecs[11] = mk(32'h0C,  1'b0, 32'h0,        32'h3,     1'b0, "div_rd3");
    vecs[12] = mk(32'h400, 1'b1, 32'h55,       32'h0,     1'b1, "err_wr_hi");
    vecs[13] = mk(32'h1000,1'b0, 32'h0,        32'h0,     1'b0, "alias_txdata");

    bus.HSELx = 1'b0; bus.HTRANS = 2'b00; bus.HADDR = '0; bus.HWRITE = 1'b0;
    bus.HSIZE = 3'b010; bus.HWDATA = '0;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    @(negedge clk);
    chk("rst_uart_tx", uart_tx, 1'b1);
    chk("rst_hready_hresp", {bus.HREADY, bus.HRESP}, 3'b100);
    chk("rst_hrdata", bus.HRDATA, 32'h0);
    cyc(1);

    for (int i = 0; i < NV; i++) begin
      ahb_xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, d, r1, p1, r2, p2);
      if (vecs[i].err) begin
        chk({vecs[i].name, "_c1"}, {r1, p1}, 3'b001);
        chk({vecs[i].name, "_c2"}, {r2, p2}, 3'b101);
      end else begin
        chk({vecs[i].name, "_resp"}, {r1, p1}, 3'b100);
        if (!vecs[i].wr) chk(vecs[i].name, d, vecs[i].exp);
      end
    end
    cur_bits = 4;

    // Address phase offered during the stall cycle must not take effect.
    bus.HSELx = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h20; bus.HWRITE = 1'b0;
    @(posedge clk); #1;
    bus.HADDR = 32'h0C; bus.HWRITE = 1'b1;
    @(negedge clk);
    chk("err_ign_c1", {bus.HREADY, bus.HRESP}, 3'b001);
    @(posedge clk); #1;
    bus.HSELx = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = 32'h5;
    @(negedge clk);
    chk("err_ign_c2", {bus.HREADY, bus.HRESP}, 3'b101);
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_ign_idle", {bus.HREADY, bus.HRESP}, 3'b100);
    cyc(1);
    rd(32'h0C, d);
    chk("err_ign_div", d, 32'h3);

    // 0xA5 at DIV=3: exact per-cycle line waveform
    wr(32'h00, 32'hA5);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) ok = 1'b1;
    end
    chk("a5_start_seen", ok, 1'b1);
    if (ok) begin
      sv[0] = uart_tx;
      for (int j = 1; j < 40; j++) begin
        @(negedge clk);
        sv[j] = uart_tx;
      end
      fr = {1'b1, 8'hA5, 1'b0};
      for (int k = 0; k < 10; k++)
        chk($sformatf("a5_slot%0d", k), sv[4*k +: 4], {4{fr[k]}});
    end
    cyc(10);

    wr(32'h00, 32'h00);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) ok = 1'b1;
    end
    chk("busy_start_seen", ok, 1'b1);
    cyc(1);
    rd(32'h08, d);
    chk("status_busy", d, 32'h6);
    cyc(60);
    rd(32'h08, d);
    chk("status_idle_after", d, 32'h2);
    mon_q.delete();

    // 10 pipelined pushes: one pop overlaps push 2, so the 10th hits a full FIFO.
    bus.HSELx = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.HWDATA = 32'h40 + i;
      if (i == 9) begin
        bus.HSELx = 1'b0; bus.HTRANS = 2'b00;
      end
    end
    cyc(1);
    rd(32'h08, d);
    chk("ovf_status", d, 32'h15);
    for (int i = 0; i < 9 * 40 + 200 && mon_q.size() < 9; i++) cyc(1);
    cyc(60);
    chk("ovf_frame_count", mon_q.size(), 9);
    for (int i = 0; i < 9 && mon_q.size() > 0; i++)
      chk($sformatf("ovf_byte%0d", i), mon_q.pop_front(), 8'h40 + i);
    wr(32'h08, 32'h10);
    rd(32'h08, d);
    chk("ovf_cleared", d, 32'h2);

    send_rx(8'h3C, 1'b1, 4);
    rd(32'h04, d);
    chk("rx_3c_first", d, 32'h8000003C);
    rd(32'h04, d);
    chk("rx_3c_second", d, 32'h0000003C);

    send_rx(8'h11, 1'b1, 4);
    send_rx(8'h22, 1'b1, 4);
    rd(32'h08, d);
    chk("ovr_status", d, 32'h2A);
    rd(32'h04, d);
    chk("ovr_rxdata", d, 32'h80000011);
    wr(32'h08, 32'h20);
    rd(32'h08, d);
    chk("ovr_cleared", d, 32'h2);

    send_rx(8'h55, 1'b0, 4);
    rd(32'h08, d);
    chk("ferr_status", d, 32'h42);
    wr(32'h08, 32'h40);
    rd(32'h08, d);
    chk("ferr_cleared", d, 32'h2);

    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_byte = 8'h11;
    mon_q.delete();
    for (int it = 0; it < 8; it++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      bits = $urandom_range(4, 10);
      wr(32'h0C, bits - 1);
      cur_bits = bits;
      send_rx(b, stop, bits);
      if (!stop) m_ferr = 1'b1;
      else if (!m_valid) begin
        m_valid = 1'b1; m_byte = b;
      end else m_ovr = 1'b1;
      rd(32'h08, d);
      chk("rand_status", d, {25'b0, m_ferr, m_ovr, 1'b0, m_valid, 1'b0, 1'b1, 1'b0});
      if ($urandom_range(0, 1) == 1) begin
        rd(32'h04, d);
        chk("rand_rxdata", d, {m_valid, 23'b0, m_byte});
        m_valid = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) begin
        wr(32'h08, 32'h60);
        m_ovr = 1'b0; m_ferr = 1'b0;
      end
      wr(32'h00, {24'b0, b});
      for (int i = 0; i < 12 * bits + 20 && mon_q.size() == 0; i++) cyc(1);
      chk("rand_tx_seen", mon_q.size() != 0, 1'b1);
      if (mon_q.size() != 0) chk("rand_tx_byte", mon_q.pop_front(), b);
      cyc(2 * bits);
    end

    // Reset in the middle of both a TX and an RX frame.
    wr(32'h08, 32'h70);
    wr(32'h0C, 32'h3);
    cur_bits = 4;
    rd(32'h04, d);
    wr(32'h00, 32'h00);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) ok = 1'b1;
    end
    chk("midrst_start_seen", ok, 1'b1);
    cyc(6);
    uart_rx = 1'b0;
    cyc(10);
    rst = 1'b1;
    #1;
    chk("midrst_tx_high", uart_tx, 1'b1);
    uart_rx = 1'b1;
    cyc(3);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    chk("midrst_line_idle", lows, 0);
    cyc(1);
    rd(32'h08, d);
    chk("midrst_status", d, 32'h2);
    rd(32'h0C, d);
    chk("midrst_div", d, 32'h1B1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
